// File: rtl/validator_bank.sv
// Golden-vector store with tolerance compare and mismatch statistics.
// Ports: clk/reset_n, data_in/address, wr_en/rd_en/cmp_en/clr_stats commands;
//   busy, data_out/output_ready, cmp_valid/cmp_match, cmp_cnt/mismatch_cnt,
//   first_err_addr/first_err_valid.
module validator_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16,
  parameter int TOL    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              cmp_en,
  input  logic              clr_stats,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              output_ready,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic [CNT_W-1:0]  cmp_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  typedef enum logic [2:0] {
    IDLE, WR_DONE, RD_DONE, CMP_EVAL, CMP_DONE
  } state_t;

  localparam logic [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] golden;
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] cap_addr;

  logic do_wr, do_rd, do_cmp, eval;
  logic [DATA_W:0] diff, mag;
  logic match;

  always_comb begin
    do_wr  = (state == IDLE) && wr_en;
    do_rd  = (state == IDLE) && !wr_en && rd_en;
    do_cmp = (state == IDLE) && !wr_en && !rd_en && cmp_en;
    eval   = (state == CMP_EVAL);
  end

  // One extra bit keeps the full signed range of the difference.
  always_comb begin
    diff = {cap_data[DATA_W-1], cap_data}
         - {golden[DATA_W-1], golden};
    mag  = diff[DATA_W] ? (~diff + 1'b1) : diff;
    match = (mag <= TOL_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (do_wr)       state_nx = WR_DONE;
        else if (do_rd)  state_nx = RD_DONE;
        else if (do_cmp) state_nx = CMP_EVAL;
      end
      WR_DONE:  state_nx = IDLE;
      RD_DONE:  state_nx = IDLE;
      CMP_EVAL: state_nx = CMP_DONE;
      CMP_DONE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[address] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out        <= '0;
      output_ready    <= 1'b0;
      cmp_valid       <= 1'b0;
      cmp_match       <= 1'b0;
      cmp_cnt         <= '0;
      mismatch_cnt    <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      golden          <= '0;
      cap_data        <= '0;
      cap_addr        <= '0;
    end else begin
      output_ready <= do_rd;
      cmp_valid    <= eval;
      if (do_rd) data_out <= mem[address];
      if (do_cmp) begin
        golden   <= mem[address];
        cap_data <= data_in;
        cap_addr <= address;
      end
      if (eval) begin
        cmp_match <= match;
        data_out  <= golden;
      end
      // Clear beats a coincident compare update.
      if (clr_stats) begin
        cmp_cnt         <= '0;
        mismatch_cnt    <= '0;
        first_err_addr  <= '0;
        first_err_valid <= 1'b0;
      end else if (eval) begin
        if (cmp_cnt != CMAX) cmp_cnt <= cmp_cnt + 1'b1;
        if (!match) begin
          if (mismatch_cnt != CMAX)
            mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_addr  <= cap_addr;
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_validator_bank.sv
// Bench for validator_bank: two instances (TOL=2/CNT_W=4, TOL=0/CNT_W=16)
// share one stimulus stream and are checked against a transaction model.
module tb_validator_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [10:0] address = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        cmp_en = 1'b0;
  logic        clr_stats = 1'b0;

  logic        busy_a, ready_a, cval_a, cmat_a, fev_a;
  logic [15:0] dout_a;
  logic [3:0]  cnt_a, mis_a;
  logic [10:0] fea_a;
  logic        busy_b, ready_b, cval_b, cmat_b, fev_b;
  logic [15:0] dout_b;
  logic [15:0] cnt_b, mis_b;
  logic [10:0] fea_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  validator_bank #(.DATA_W(16), .ADDR_W(11), .CNT_W(4), .TOL(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .address(address),
    .wr_en(wr_en), .rd_en(rd_en), .cmp_en(cmp_en), .clr_stats(clr_stats),
    .busy(busy_a), .data_out(dout_a), .output_ready(ready_a),
    .cmp_valid(cval_a), .cmp_match(cmat_a), .cmp_cnt(cnt_a),
    .mismatch_cnt(mis_a), .first_err_addr(fea_a),
    .first_err_valid(fev_a)
  );

  validator_bank #(.DATA_W(16), .ADDR_W(11), .CNT_W(16), .TOL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .address(address),
    .wr_en(wr_en), .rd_en(rd_en), .cmp_en(cmp_en), .clr_stats(clr_stats),
    .busy(busy_b), .data_out(dout_b), .output_ready(ready_b),
    .cmp_valid(cval_b), .cmp_match(cmat_b), .cmp_cnt(cnt_b),
    .mismatch_cnt(mis_b), .first_err_addr(fea_b),
    .first_err_valid(fev_b)
  );

  // Reference model: golden memory plus per-instance statistics.
  logic [15:0] gm [int];
  int          addrs [$];
  int          tol  [2] = '{2, 0};
  int          cmax [2] = '{15, 65535};
  int          cnt  [2];
  int          mis  [2];
  int          fea  [2];
  int          fev  [2];
  bit          last_m [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_match(int i, logic [15:0] d,
                                     logic [15:0] g);
    int df;
    df = int'($signed(d)) - int'($signed(g));
    if (df < 0) df = -df;
    return df <= tol[i];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; mis[i] = 0; fea[i] = 0; fev[i] = 0;
    end
  endfunction

  function automatic void model_cmp(int i, bit m, int a);
    if (cnt[i] < cmax[i]) cnt[i]++;
    if (!m) begin
      if (mis[i] < cmax[i]) mis[i]++;
      if (fev[i] == 0) begin fea[i] = a; fev[i] = 1; end
    end
  endfunction

  task automatic chk_stats();
    chk("cnt_a", 32'(cnt_a), cnt[0]);
    chk("mis_a", 32'(mis_a), mis[0]);
    chk("fea_a", 32'(fea_a), fea[0]);
    chk("fev_a", 32'(fev_a), fev[0]);
    chk("cnt_b", 32'(cnt_b), cnt[1]);
    chk("mis_b", 32'(mis_b), mis[1]);
    chk("fea_b", 32'(fea_b), fea[1]);
    chk("fev_b", 32'(fev_b), fev[1]);
  endtask

  task automatic issue(input bit w, input bit r, input bit c,
                       input int a, input int d, input bit clr);
    bit kw, kr, kc;
    bit m [2];
    logic [15:0] g;
    kw = w;
    kr = !w && r;
    kc = !w && !r && c;
    @(negedge clk);
    chk("idle_busy", 32'(busy_a | busy_b), 0);
    wr_en = w; rd_en = r; cmp_en = c;
    address = 11'(a); data_in = 16'(d);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; cmp_en = 0;
    if (kw) begin
      gm[a] = 16'(d);
      addrs.push_back(a);
      chk("wr_busy", 32'(busy_a & busy_b), 1);
      chk("wr_nordy", 32'(ready_a | ready_b), 0);
      @(posedge clk); #1;
      chk("wr_free", 32'(busy_a | busy_b), 0);
      chk("wr_nordy2", 32'(ready_a | ready_b), 0);
    end else if (kr) begin
      chk("rd_rdy", 32'(ready_a & ready_b), 1);
      chk("rd_da", 32'(dout_a), 32'(gm[a]));
      chk("rd_db", 32'(dout_b), 32'(gm[a]));
      @(posedge clk); #1;
      chk("rd_rdy_off", 32'(ready_a | ready_b), 0);
      chk("rd_free", 32'(busy_a | busy_b), 0);
    end else if (kc) begin
      g = gm[a];
      if (clr) clr_stats = 1'b1;
      chk("cmp_busy", 32'(busy_a & busy_b), 1);
      chk("cmp_early", 32'(cval_a | cval_b), 0);
      @(posedge clk); #1;
      clr_stats = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m[i] = model_match(i, 16'(d), g);
        last_m[i] = m[i];
        if (!clr) model_cmp(i, m[i], a);
      end
      if (clr) model_clear();
      chk("cmp_valid", 32'(cval_a & cval_b), 1);
      chk("cmp_match_a", 32'(cmat_a), 32'(m[0]));
      chk("cmp_match_b", 32'(cmat_b), 32'(m[1]));
      chk("cmp_gold_a", 32'(dout_a), 32'(g));
      chk("cmp_gold_b", 32'(dout_b), 32'(g));
      chk_stats();
      @(posedge clk); #1;
      chk("cmp_vld_off", 32'(cval_a | cval_b), 0);
      chk("cmp_free", 32'(busy_a | busy_b), 0);
      chk("cmp_hold_a", 32'(cmat_a), 32'(m[0]));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a"}, {busy_a, ready_a, cval_a, cmat_a, fev_a,
                      dout_a, cnt_a, mis_a, fea_a}, 0);
    chk({tag, "_b"}, {busy_b, ready_b, cval_b, cmat_b, fev_b,
                      fea_b, 16'(dout_b ^ cnt_b ^ mis_b)}, 0);
    chk({tag, "_bc"}, {cnt_b, mis_b}, 0);
  endtask

  initial begin
    int a, d;
    model_clear();
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("rst_low");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("rst_rel");

    // Write / read
    issue(1, 0, 0, 'h005, 'h1234, 0);
    issue(0, 1, 0, 'h005, 0, 0);
    chk("rd_1234", 32'(dout_a), 'h1234);

    // Tolerance compares
    issue(1, 0, 0, 'h0A0, 'h0010, 0);
    issue(1, 0, 0, 'h0A1, 'h0010, 0);
    issue(0, 0, 1, 'h0A0, 'h0012, 0);
    chk("tol_in_a", 32'(cmat_a), 1);
    issue(0, 0, 1, 'h0A0, 'h000D, 0);
    chk("tol_out_a", 32'(cmat_a), 0);
    chk("mis1_a", 32'(mis_a), 1);
    issue(0, 0, 1, 'h0A1, 'h0020, 0);
    chk("fea_keep", 32'(fea_a), 'h0A0);
    chk("fev_set", 32'(fev_a), 1);
    chk("cnt3", 32'(cnt_a), 3);

    // Signed extremes
    issue(1, 0, 0, 'h100, 'h8000, 0);
    issue(0, 0, 1, 'h100, 'h7FFF, 0);
    chk("ext_mis_b", 32'(cmat_b), 0);
    issue(0, 0, 1, 'h100, 'h8000, 0);
    chk("ext_eq_b", 32'(cmat_b), 1);

    // Priority: write beats read
    issue(1, 1, 0, 'h005, 'h5A5A, 0);
    issue(0, 1, 0, 'h005, 0, 0);
    chk("prio_data", 32'(dout_b), 'h5A5A);

    // Read while busy is dropped
    @(negedge clk);
    wr_en = 1; address = 11'h200; data_in = 16'h0BEE;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 1; address = 11'h005;
    gm['h200] = 16'h0BEE; addrs.push_back('h200);
    @(posedge clk); #1;
    rd_en = 0;
    chk("busy_rd_ign", 32'(ready_a | ready_b), 0);
    chk("busy_rd_free", 32'(busy_a | busy_b), 0);
    @(posedge clk); #1;
    chk("busy_rd_ign2", 32'(ready_a | ready_b), 0);

    // Saturation of the narrow counters
    for (int i = 0; i < 20; i++) issue(0, 0, 1, 'h100, 'h0000, 0);
    chk("sat_mis_a", 32'(mis_a), 15);
    chk("sat_cnt_a", 32'(cnt_a), 15);

    // Clear during CMP_EVAL
    issue(0, 0, 1, 'h0A0, 'h0100, 1);
    chk("clr_cnt_a", 32'(cnt_a), 0);
    chk("clr_fev_b", 32'(fev_b), 0);

    // Reset during CMP_EVAL
    @(negedge clk);
    cmp_en = 1; address = 11'h0A0; data_in = 16'h7777;
    @(posedge clk); #1;
    cmp_en = 0;
    #2 reset_n = 1'b0;
    #1;
    chk_zero_outputs("rst_mid");
    model_clear();
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_vld", 32'(cval_a | cval_b), 0);
    end
    chk_stats();

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      a = addrs[$urandom_range(0, addrs.size() - 1)];
      if (k < 2) begin
        a = $urandom_range(0, 2047);
        issue(1, $urandom_range(0, 1), $urandom_range(0, 1),
              a, $urandom_range(0, 65535), 0);
      end else if (k < 4) begin
        issue(0, 1, $urandom_range(0, 1), a, 0, 0);
      end else begin
        d = int'(gm[a]) + $urandom_range(0, 8) - 4;
        if (k == 9) d = $urandom_range(0, 65535);
        issue(0, 0, 1, a, d & 'hFFFF, ($urandom_range(0, 15) == 0));
      end
    end
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
